// File: rtl/sr_latch_seq_ctrl_if.sv
// Command/response handshake bundle for sr_latch_seq_ctrl.
// slave = controller side, master = bus-side requester.
interface sr_latch_seq_ctrl_if #(
  parameter int unsigned IDX_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [IDX_W-1:0] cmd_idx;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_q;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_q, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, rsp_ready,
    output cmd_ready, rsp_valid, rsp_q, rsp_err
  );
endinterface

// File: rtl/sr_latch_seq_ctrl.sv
// Sequencer issuing exclusive fixed-width set/reset pulses to an SR latch bank.
// Optional write-back check enabled by defining SR_LATCH_SEQ_VERIFY_EN.
module sr_latch_seq_ctrl #(
  parameter int unsigned N_LATCH    = 8,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_latch_seq_ctrl_if.slave bus,
  output logic [N_LATCH-1:0] set_o,
  output logic [N_LATCH-1:0] reset_o,
  input  logic [N_LATCH-1:0] latch_q,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_SETTLE, S_RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_SET, OP_RESET, OP_TOGGLE} op_t;

  localparam int unsigned QW        = 1 << IDX_W;
  localparam int unsigned CNT_MAX   = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_is_set, w_is_set_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [N_LATCH-1:0] r_set, w_set_nxt;
  logic [N_LATCH-1:0] r_rst, w_rst_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic               r_rsp_q, w_rsp_q_nxt;
  logic               r_rsp_err, w_rsp_err_nxt;
  logic               r_busy, w_busy_nxt;

  // Zero-padded to the full index range so out-of-range indices read 0.
  logic [QW-1:0]      w_q_pad;
  logic               w_cmd_q;
  logic               w_cur_q;
  logic               w_bad_idx;
  logic               w_cmd_set;
  logic [N_LATCH-1:0] w_cmd_hot;
  logic [N_LATCH-1:0] w_cur_hot;
  logic               w_wb_err;

  assign w_q_pad   = QW'(latch_q);
  assign w_cmd_q   = w_q_pad[bus.cmd_idx];
  assign w_cur_q   = w_q_pad[r_idx];
  assign w_bad_idx = (32'(bus.cmd_idx) >= N_LATCH);
  assign w_cmd_set = (bus.cmd_op == OP_SET) || ((bus.cmd_op == OP_TOGGLE) && !w_cmd_q);
  assign w_cmd_hot = N_LATCH'(1) << bus.cmd_idx;
  assign w_cur_hot = N_LATCH'(1) << r_idx;

`ifdef SR_LATCH_SEQ_VERIFY_EN
  assign w_wb_err = (w_cur_q != r_is_set);
`else
  assign w_wb_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_is_set_nxt    = r_is_set;
    w_cnt_nxt       = r_cnt;
    w_set_nxt       = '0;
    w_rst_nxt       = '0;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_q_nxt     = r_rsp_q;
    w_rsp_err_nxt   = r_rsp_err;

    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_idx_nxt    = bus.cmd_idx;
          w_is_set_nxt = w_cmd_set;
          if (w_bad_idx) begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_q_nxt     = 1'b0;
            w_rsp_err_nxt   = 1'b1;
          end else if (bus.cmd_op == OP_READ) begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_q_nxt     = w_cmd_q;
            w_rsp_err_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_PULSE;
            w_cnt_nxt   = PULSE_LD;
            if (w_cmd_set) w_set_nxt = w_cmd_hot;
            else           w_rst_nxt = w_cmd_hot;
          end
        end
      end

      S_PULSE: begin
        if (r_cnt == '0) begin
          if (SETTLE_CYC == 0) begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_q_nxt     = w_cur_q;
            w_rsp_err_nxt   = w_wb_err;
          end else begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = SETTLE_LD;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          if (r_is_set) w_set_nxt = w_cur_hot;
          else          w_rst_nxt = w_cur_hot;
        end
      end

      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_q_nxt     = w_cur_q;
          w_rsp_err_nxt   = w_wb_err;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_rsp_valid_nxt = 1'b0;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // Async clear also drops any in-flight pulse without waiting for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_is_set    <= 1'b0;
      r_cnt       <= '0;
      r_set       <= '0;
      r_rst       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_q     <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_is_set    <= w_is_set_nxt;
      r_cnt       <= w_cnt_nxt;
      r_set       <= w_set_nxt;
      r_rst       <= w_rst_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_q     <= w_rsp_q_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_q     = r_rsp_q;
  assign bus.rsp_err   = r_rsp_err;
  assign set_o         = r_set;
  assign reset_o       = r_rst;
  assign busy          = r_busy;

endmodule
